watchdog_kicker: RTL and testbench

Supervisor-side partner of the watchdog timer. It drives the watchdog's `flag` input: holds it high while the supervised logic is armed, and drops it briefly to kick (clear) the watchdog whenever the client reports liveness. When the watchdog raises `interrupt`, it runs a recovery request/acknowledge handshake with the system controller, counts faults, and escalates to a permanent lockout after `MAX_FAULTS` recoveries.

---
 rtl/watchdog_kicker_if.sv | 26 ++
 rtl/watchdog_kicker.sv | 115 +++++++++++
 tb/tb_watchdog_kicker.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/watchdog_kicker_if.sv
// Bundles the watchdog_kicker control/status signals between the system side and the kicker.
// slave = kicker view, master = system/controller view.
interface watchdog_kicker_if #(
  parameter int MAX_FAULTS = 3
) ();
  localparam int FCW = $clog2(MAX_FAULTS + 1);

  logic           en;
  logic           alive;
  logic           interrupt;
  logic           recover_ack;
  logic           flag;
  logic           recover_req;
  logic [FCW-1:0] fault_count;
  logic           lockout;

  modport slave (
    input  en, alive, interrupt, recover_ack,
    output flag, recover_req, fault_count, lockout
  );

  modport master (
    output en, alive, interrupt, recover_ack,
    input  flag, recover_req, fault_count, lockout
  );
endinterface

// File: rtl/watchdog_kicker.sv
// Drives the watchdog flag (high = counting, low = cleared), kicks on liveness, and runs
// recovery handshakes on timeout; all outputs are registered and decoded from next state.
module watchdog_kicker #(
  parameter int KICK_LEN   = 1,
  parameter int MAX_FAULTS = 3
) (
  input  logic               clk,
  input  logic               rstn,
  watchdog_kicker_if.slave   bus
);
  localparam int FCW = $clog2(MAX_FAULTS + 1);
  localparam int KW  = $clog2(KICK_LEN + 1);
  localparam logic [KW-1:0]  KICK_LOAD = KW'(KICK_LEN - 1);
  localparam logic [FCW-1:0] FC_MAX    = FCW'(MAX_FAULTS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_KICK,
    S_RECOVER,
    S_LOCKOUT
  } state_t;

  state_t         state_q, state_d;
  logic [KW-1:0]  kick_cnt_q, kick_cnt_d;
  logic [FCW-1:0] fault_count_q, fault_count_d;
  logic           flag_q, flag_d;
  logic           recover_req_q, recover_req_d;
  logic           lockout_q, lockout_d;

  always_comb begin
    state_d       = state_q;
    kick_cnt_d    = kick_cnt_q;
    fault_count_d = fault_count_q;

    case (state_q)
      S_IDLE: begin
        if (bus.en) state_d = S_ARMED;
      end
      S_ARMED: begin
        if (!bus.en) begin
          state_d = S_IDLE;
        end else if (bus.interrupt) begin
          state_d = S_RECOVER;
        end else if (bus.alive) begin
          state_d    = S_KICK;
          kick_cnt_d = KICK_LOAD;
        end
      end
      S_KICK: begin
        // alive is deliberately not looked at here: kicks never extend or queue
        if (!bus.en) begin
          state_d = S_IDLE;
        end else if (bus.interrupt) begin
          state_d = S_RECOVER;
        end else if (kick_cnt_q == '0) begin
          state_d = S_ARMED;
        end else begin
          kick_cnt_d = kick_cnt_q - 1'b1;
        end
      end
      S_RECOVER: begin
        // fault_count already includes this recovery, so reaching the limit escalates
        if (bus.recover_ack) begin
          if (fault_count_q == FC_MAX) begin
            state_d = S_LOCKOUT;
          end else if (bus.en) begin
            state_d = S_ARMED;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_LOCKOUT: begin
        state_d = S_LOCKOUT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (state_d != S_KICK) kick_cnt_d = '0;

    if ((state_d == S_RECOVER) && (state_q != S_RECOVER) && (fault_count_q != FC_MAX)) begin
      fault_count_d = fault_count_q + 1'b1;
    end

    flag_d        = (state_d == S_ARMED);
    recover_req_d = (state_d == S_RECOVER);
    lockout_d     = (state_d == S_LOCKOUT);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= S_IDLE;
      kick_cnt_q    <= '0;
      fault_count_q <= '0;
      flag_q        <= 1'b0;
      recover_req_q <= 1'b0;
      lockout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      kick_cnt_q    <= kick_cnt_d;
      fault_count_q <= fault_count_d;
      flag_q        <= flag_d;
      recover_req_q <= recover_req_d;
      lockout_q     <= lockout_d;
    end
  end

  assign bus.flag        = flag_q;
  assign bus.recover_req = recover_req_q;
  assign bus.fault_count = fault_count_q;
  assign bus.lockout     = lockout_q;
endmodule

// File: tb/tb_watchdog_kicker.sv
// Self-checking bench for watchdog_kicker: directed scenarios plus randomized traffic
// compared against a behavioural model of the supervision rules.
module tb_watchdog_kicker;
  localparam int KL   = 3;
  localparam int MAXF = 3;
  localparam int FCW  = $clog2(MAXF + 1);

  logic clk = 1'b0;
  logic rstn;
  int   n_checks = 0;
  int   n_fail   = 0;

  watchdog_kicker_if #(.MAX_FAULTS(MAXF)) bus ();

  watchdog_kicker #(.KICK_LEN(KL), .MAX_FAULTS(MAXF)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic e, input logic a, input logic i, input logic k);
    bus.en          = e;
    bus.alive       = a;
    bus.interrupt   = i;
    bus.recover_ack = k;
  endtask

  // Inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    drive(0, 0, 0, 0);
    tick(); tick();
    if (bus.flag !== 1'b0) begin n_fail++; $display("FAIL rst_flag: got %b want 0", bus.flag); end
    n_checks++;
    if (bus.recover_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", bus.recover_req); end
    n_checks++;
    if (bus.lockout !== 1'b0) begin n_fail++; $display("FAIL rst_lockout: got %b want 0", bus.lockout); end
    n_checks++;
    if (bus.fault_count !== '0) begin n_fail++; $display("FAIL rst_fc: got %0d want 0", bus.fault_count); end
    n_checks++;
    rstn = 1'b1;
    drive(1, 0, 0, 0);
    if (bus.flag !== 1'b0) begin n_fail++; $display("FAIL en_before_edge: got %b want 0", bus.flag); end
    n_checks++;
    tick();
    if (bus.flag !== 1'b1) begin n_fail++; $display("FAIL en_flag: got %b want 1", bus.flag); end
    n_checks++;
  endtask

  task automatic test_kick();
    tick(); tick();
    drive(1, 1, 0, 0);
    tick();                          // alive sampled at edge k
    drive(1, 0, 0, 0);
    if (bus.flag !== 1'b0) begin n_fail++; $display("FAIL kick_k1: got %b want 0", bus.flag); end
    n_checks++;
    tick();
    if (bus.flag !== 1'b0) begin n_fail++; $display("FAIL kick_k2: got %b want 0", bus.flag); end
    n_checks++;
    drive(1, 1, 0, 0);               // second alive at edge k+2 must be ignored
    tick();
    drive(1, 0, 0, 0);
    if (bus.flag !== 1'b0) begin n_fail++; $display("FAIL kick_k3: got %b want 0", bus.flag); end
    n_checks++;
    tick();
    if (bus.flag !== 1'b1) begin n_fail++; $display("FAIL kick_k4: got %b want 1", bus.flag); end
    n_checks++;
    tick();
    if (bus.flag !== 1'b1) begin n_fail++; $display("FAIL kick_noext: got %b want 1", bus.flag); end
    n_checks++;
  endtask

  // Small watchdog: counts while flag is high, fires a one-cycle interrupt at 32.
  task automatic test_recover();
    int  wd = 0;
    bit  fired = 0;
    for (int c = 0; c < 200 && !fired; c++) begin
      if (bus.flag) wd++; else wd = 0;
      if (wd == 32) fired = 1;
      else tick();
    end
    if (!fired) begin n_fail++; $display("FAIL wd_timeout: got no interrupt want one within 200 cycles"); end
    n_checks++;
    drive(1, 0, 1, 0);
    tick();
    drive(1, 0, 0, 0);
    if (bus.recover_req !== 1'b1) begin n_fail++; $display("FAIL rec_req: got %b want 1", bus.recover_req); end
    n_checks++;
    if (bus.flag !== 1'b0) begin n_fail++; $display("FAIL rec_flag: got %b want 0", bus.flag); end
    n_checks++;
    if (bus.fault_count !== FCW'(1)) begin n_fail++; $display("FAIL rec_fc: got %0d want 1", bus.fault_count); end
    n_checks++;
    repeat (5) tick();
    if (bus.recover_req !== 1'b1) begin n_fail++; $display("FAIL rec_hold: got %b want 1", bus.recover_req); end
    n_checks++;
    drive(1, 0, 0, 1);
    tick();
    drive(1, 0, 0, 0);
    if (bus.recover_req !== 1'b0) begin n_fail++; $display("FAIL ack_req: got %b want 0", bus.recover_req); end
    n_checks++;
    if (bus.flag !== 1'b1) begin n_fail++; $display("FAIL ack_flag: got %b want 1", bus.flag); end
    n_checks++;
  endtask

  task automatic test_simultaneous();
    drive(1, 1, 1, 0);
    tick();
    drive(1, 0, 0, 1);               // ack on the first recovery cycle
    if (bus.recover_req !== 1'b1 || bus.flag !== 1'b0) begin
      n_fail++; $display("FAIL int_alive: got req=%b flag=%b want req=1 flag=0", bus.recover_req, bus.flag);
    end
    n_checks++;
    if (bus.fault_count !== FCW'(2)) begin n_fail++; $display("FAIL int_alive_fc: got %0d want 2", bus.fault_count); end
    n_checks++;
    tick();
    drive(1, 0, 0, 0);
    if (bus.flag !== 1'b1 || bus.recover_req !== 1'b0) begin
      n_fail++; $display("FAIL min_roundtrip: got flag=%b req=%b want flag=1 req=0", bus.flag, bus.recover_req);
    end
    n_checks++;
    tick();
    if (bus.flag !== 1'b1) begin n_fail++; $display("FAIL no_kick_after: got %b want 1", bus.flag); end
    n_checks++;
    drive(0, 0, 1, 0);
    tick();
    drive(0, 0, 0, 0);
    if (bus.flag !== 1'b0 || bus.recover_req !== 1'b0) begin
      n_fail++; $display("FAIL en_wins: got flag=%b req=%b want flag=0 req=0", bus.flag, bus.recover_req);
    end
    n_checks++;
    if (bus.fault_count !== FCW'(2)) begin n_fail++; $display("FAIL en_wins_fc: got %0d want 2", bus.fault_count); end
    n_checks++;
    drive(1, 0, 0, 0);
    tick();
    if (bus.flag !== 1'b1) begin n_fail++; $display("FAIL rearm: got %b want 1", bus.flag); end
    n_checks++;
  endtask

  task automatic test_midreset();
    rstn = 1'b0;
    drive(1, 0, 0, 0);
    tick();
    rstn = 1'b1;
    tick();
    drive(1, 0, 1, 0); tick();
    drive(1, 0, 0, 1); tick();
    drive(1, 0, 1, 0); tick();
    drive(1, 0, 0, 0);
    if (bus.recover_req !== 1'b1 || bus.fault_count !== FCW'(2)) begin
      n_fail++; $display("FAIL mid_setup: got req=%b fc=%0d want req=1 fc=2", bus.recover_req, bus.fault_count);
    end
    n_checks++;
    #2 rstn = 1'b0;
    #1;
    if (bus.recover_req !== 1'b0 || bus.flag !== 1'b0 || bus.lockout !== 1'b0 || bus.fault_count !== '0) begin
      n_fail++; $display("FAIL async_rst: got req=%b flag=%b lock=%b fc=%0d want all 0",
                         bus.recover_req, bus.flag, bus.lockout, bus.fault_count);
    end
    n_checks++;
    tick();
    rstn = 1'b1;
    if (bus.flag !== 1'b0) begin n_fail++; $display("FAIL post_rst_idle: got %b want 0", bus.flag); end
    n_checks++;
    tick();
    if (bus.flag !== 1'b1) begin n_fail++; $display("FAIL post_rst_arm: got %b want 1", bus.flag); end
    n_checks++;
  endtask

  task automatic test_lockout();
    rstn = 1'b0;
    drive(1, 0, 0, 0);
    tick();
    rstn = 1'b1;
    tick();
    for (int f = 1; f <= MAXF; f++) begin
      drive(1, 0, 1, 0); tick();
      drive(1, 0, 0, 0);
      if (bus.recover_req !== 1'b1 || bus.fault_count !== FCW'(f)) begin
        n_fail++; $display("FAIL lk_entry%0d: got req=%b fc=%0d want req=1 fc=%0d", f, bus.recover_req, bus.fault_count, f);
      end
      n_checks++;
      tick(); tick();
      drive(1, 0, 0, 1); tick();
      drive(1, 0, 0, 0);
      if (f < MAXF) begin
        if (bus.flag !== 1'b1 || bus.lockout !== 1'b0) begin
          n_fail++; $display("FAIL lk_rearm%0d: got flag=%b lock=%b want flag=1 lock=0", f, bus.flag, bus.lockout);
        end
        n_checks++;
      end
    end
    if (bus.lockout !== 1'b1 || bus.flag !== 1'b0 || bus.recover_req !== 1'b0 || bus.fault_count !== FCW'(MAXF)) begin
      n_fail++; $display("FAIL lk_final: got lock=%b flag=%b req=%b fc=%0d want 1 0 0 %0d",
                         bus.lockout, bus.flag, bus.recover_req, bus.fault_count, MAXF);
    end
    n_checks++;
    for (int c = 0; c < 20; c++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      tick();
      if (bus.lockout !== 1'b1 || bus.flag !== 1'b0 || bus.recover_req !== 1'b0 || bus.fault_count !== FCW'(MAXF)) begin
        n_fail++; $display("FAIL lk_sticky c%0d: got lock=%b flag=%b req=%b fc=%0d", c,
                           bus.lockout, bus.flag, bus.recover_req, bus.fault_count);
      end
      n_checks++;
    end
  endtask

  task automatic test_random();
    bit   m_act, m_req, m_lock;
    int   m_kick, m_fc;
    logic e, a, i, k, exp_flag;
    for (int c = 0; c < 3000; c++) begin
      if (c % 150 == 0) begin
        rstn = 1'b0;
        #1;
        rstn = 1'b1;
        m_act = 0; m_req = 0; m_lock = 0; m_kick = 0; m_fc = 0;
      end
      e = ($urandom_range(0, 15) != 0);
      a = ($urandom_range(0, 3) == 0);
      i = ($urandom_range(0, 11) == 0);
      k = ($urandom_range(0, 2) == 0);
      drive(e, a, i, k);
      tick();
      // m_kick = number of flag-low kick cycles still to come
      if (m_lock) begin
      end else if (m_req) begin
        if (k) begin
          m_req = 0;
          if (m_fc == MAXF) m_lock = 1;
          else m_act = e;
        end
      end else if (!m_act) begin
        m_act = e;
      end else if (!e) begin
        m_act = 0; m_kick = 0;
      end else if (i) begin
        m_act = 0; m_kick = 0; m_req = 1;
        if (m_fc < MAXF) m_fc++;
      end else if (m_kick > 0) begin
        m_kick--;
      end else if (a) begin
        m_kick = KL;
      end
      exp_flag = m_act && (m_kick == 0);
      if (bus.flag !== exp_flag) begin n_fail++; $display("FAIL rnd_flag c%0d: got %b want %b", c, bus.flag, exp_flag); end
      n_checks++;
      if (bus.recover_req !== m_req) begin n_fail++; $display("FAIL rnd_req c%0d: got %b want %b", c, bus.recover_req, m_req); end
      n_checks++;
      if (bus.lockout !== m_lock) begin n_fail++; $display("FAIL rnd_lock c%0d: got %b want %b", c, bus.lockout, m_lock); end
      n_checks++;
      if (bus.fault_count !== FCW'(m_fc)) begin n_fail++; $display("FAIL rnd_fc c%0d: got %0d want %0d", c, bus.fault_count, m_fc); end
      n_checks++;
    end
  endtask

  initial begin
    rstn = 1'b0;
    drive(0, 0, 0, 0);
    test_reset();
    test_kick();
    test_recover();
    test_simultaneous();
    test_midreset();
    test_lockout();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
